// File: rtl/cpu_types_pkg.sv
// ============================================================================
//  Module   : cpu_types_pkg
//  Brief    : Shared CPU pipeline types: ALU/select encodings and ID/EX bundle.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_types_pkg;

   localparam int C_DATA_W     = 32;
   localparam int C_REG_ADDR_W = 5;
   localparam int C_SHAMT_W    = 5;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_NOR  = 4'd5,
      ALU_SLT  = 4'd6,
      ALU_SLTU = 4'd7,
      ALU_SLL  = 4'd8,
      ALU_SRL  = 4'd9,
      ALU_SRA  = 4'd10,
      ALU_LUI  = 4'd11
   } aluop_t;

   // Code 3 is reserved; it is stored verbatim and read downstream as SRC_REG.
   typedef enum logic [1:0] {
      SRC_REG   = 2'd0,
      SRC_IMM   = 2'd1,
      SRC_SHAMT = 2'd2,
      SRC_RSVD  = 2'd3
   } alusrc_t;

   typedef enum logic [1:0] {
      RD_RT   = 2'd0,
      RD_RD   = 2'd1,
      RD_R31  = 2'd2,
      RD_RSVD = 2'd3
   } regdst_t;

   typedef struct packed {
      logic                    valid;
      logic [C_DATA_W-1:0]     pc4;
      logic [C_DATA_W-1:0]     read_reg1;
      logic [C_DATA_W-1:0]     read_reg2;
      logic [C_DATA_W-1:0]     ext_imm;
      logic [C_SHAMT_W-1:0]    shamt;
      alusrc_t                 alu_src;
      aluop_t                  alu_op;
      logic [C_REG_ADDR_W-1:0] rt;
      logic [C_REG_ADDR_W-1:0] rd;
      regdst_t                 reg_dst;
      logic                    reg_write;
      logic                    mem_read;
      logic                    mem_write;
      logic                    mem_to_reg;
      logic                    branch;
      logic                    jump;
      logic                    halt;
   } id_ex_t;

   localparam id_ex_t ID_EX_BUBBLE = '0;

endpackage

`default_nettype wire

// File: rtl/id_ex_latch_sat_counter.sv
// ============================================================================
//  Module   : sat_counter
//  Brief    : Up-counter that sticks at all-ones instead of wrapping.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clear,
   output logic [W-1:0] count
);

   logic [W-1:0] r_count;
   logic         w_at_max;

   assign w_at_max = &r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (clear) begin
         r_count <= '0;
      end else if (inc && !w_at_max) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/id_ex_latch.sv
// ============================================================================
//  Module   : id_ex_latch
//  Brief    : ID/EX pipeline register with stall, flush and stall-cycle count.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_latch
   import cpu_types_pkg::*;
#(
   // Field widths of id_ex_t are fixed by cpu_types_pkg; these must match it.
   parameter int DATA_W     = C_DATA_W,
   parameter int REG_ADDR_W = C_REG_ADDR_W,
   parameter int CNT_W      = 32
) (
   input  logic                  CLK,
   input  logic                  nRST,
   input  logic                  enable,
   input  logic                  flush,
   input  logic                  valid_in,
   input  logic [DATA_W-1:0]     pc4_in,
   input  logic [DATA_W-1:0]     readReg1_in,
   input  logic [DATA_W-1:0]     readReg2_in,
   input  logic [DATA_W-1:0]     extendedImmediate_in,
   input  logic [4:0]            shiftAmount_in,
   input  logic [1:0]            aluSource_in,
   input  logic [3:0]            aluOp_in,
   input  logic [REG_ADDR_W-1:0] rt_in,
   input  logic [REG_ADDR_W-1:0] rd_in,
   input  logic [1:0]            regDst_in,
   input  logic                  regWrite_in,
   input  logic                  memRead_in,
   input  logic                  memWrite_in,
   input  logic                  memToReg_in,
   input  logic                  branch_in,
   input  logic                  jump_in,
   input  logic                  halt_in,
   output logic                  valid_out,
   output logic [DATA_W-1:0]     pc4_out,
   output logic [DATA_W-1:0]     readReg1_out,
   output logic [DATA_W-1:0]     readReg2_out,
   output logic [DATA_W-1:0]     extendedImmediate_out,
   output logic [4:0]            shiftAmount_out,
   output logic [1:0]            aluSource_out,
   output logic [3:0]            aluOp_out,
   output logic [REG_ADDR_W-1:0] rt_out,
   output logic [REG_ADDR_W-1:0] rd_out,
   output logic [1:0]            regDst_out,
   output logic                  regWrite_out,
   output logic                  memRead_out,
   output logic                  memWrite_out,
   output logic                  memToReg_out,
   output logic                  branch_out,
   output logic                  jump_out,
   output logic                  halt_out,
   output logic [CNT_W-1:0]      stall_cycles
);

   id_ex_t w_next;
   id_ex_t r_q;
   logic   w_stall;

   always_comb begin
      w_next            = ID_EX_BUBBLE;
      w_next.valid      = valid_in;
      w_next.pc4        = pc4_in;
      w_next.read_reg1  = readReg1_in;
      w_next.read_reg2  = readReg2_in;
      w_next.ext_imm    = extendedImmediate_in;
      w_next.shamt      = shiftAmount_in;
      w_next.alu_src    = alusrc_t'(aluSource_in);
      w_next.alu_op     = aluop_t'(aluOp_in);
      w_next.rt         = rt_in;
      w_next.rd         = rd_in;
      w_next.reg_dst    = regdst_t'(regDst_in);
      w_next.reg_write  = regWrite_in;
      w_next.mem_read   = memRead_in;
      w_next.mem_write  = memWrite_in;
      w_next.mem_to_reg = memToReg_in;
      w_next.branch     = branch_in;
      w_next.jump       = jump_in;
      w_next.halt       = halt_in;
   end

   // Flush takes priority over stall; controls are not re-masked by valid.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_q <= ID_EX_BUBBLE;
      end else if (flush) begin
         r_q <= ID_EX_BUBBLE;
      end else if (enable) begin
         r_q <= w_next;
      end
   end

   assign w_stall = !flush && !enable;

   sat_counter #(
      .W (CNT_W)
   ) u_stall_cnt (
      .clk   (CLK),
      .rst_n (nRST),
      .inc   (w_stall),
      .clear (1'b0),
      .count (stall_cycles)
   );

   assign valid_out             = r_q.valid;
   assign pc4_out               = r_q.pc4;
   assign readReg1_out          = r_q.read_reg1;
   assign readReg2_out          = r_q.read_reg2;
   assign extendedImmediate_out = r_q.ext_imm;
   assign shiftAmount_out       = r_q.shamt;
   assign aluSource_out         = r_q.alu_src;
   assign aluOp_out             = r_q.alu_op;
   assign rt_out                = r_q.rt;
   assign rd_out                = r_q.rd;
   assign regDst_out            = r_q.reg_dst;
   assign regWrite_out          = r_q.reg_write;
   assign memRead_out           = r_q.mem_read;
   assign memWrite_out          = r_q.mem_write;
   assign memToReg_out          = r_q.mem_to_reg;
   assign branch_out            = r_q.branch;
   assign jump_out              = r_q.jump;
   assign halt_out              = r_q.halt;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_latch.sv
// ============================================================================
//  Module   : tb_id_ex_latch
//  Brief    : Directed self-checking bench for id_ex_latch (4-bit stall counter).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ex_latch;

   localparam int DATA_W     = 32;
   localparam int REG_ADDR_W = 5;
   localparam int CNT_W      = 4;

   logic                  CLK = 1'b0;
   logic                  nRST;
   logic                  enable, flush, valid_in;
   logic [DATA_W-1:0]     pc4_in, readReg1_in, readReg2_in, extendedImmediate_in;
   logic [4:0]            shiftAmount_in;
   logic [1:0]            aluSource_in, regDst_in;
   logic [3:0]            aluOp_in;
   logic [REG_ADDR_W-1:0] rt_in, rd_in;
   logic                  regWrite_in, memRead_in, memWrite_in, memToReg_in;
   logic                  branch_in, jump_in, halt_in;

   logic                  valid_out;
   logic [DATA_W-1:0]     pc4_out, readReg1_out, readReg2_out, extendedImmediate_out;
   logic [4:0]            shiftAmount_out;
   logic [1:0]            aluSource_out, regDst_out;
   logic [3:0]            aluOp_out;
   logic [REG_ADDR_W-1:0] rt_out, rd_out;
   logic                  regWrite_out, memRead_out, memWrite_out, memToReg_out;
   logic                  branch_out, jump_out, halt_out;
   logic [CNT_W-1:0]      stall_cycles;

   int total = 0;
   int bad   = 0;

   always #5 CLK = ~CLK;

   id_ex_latch #(
      .DATA_W     (DATA_W),
      .REG_ADDR_W (REG_ADDR_W),
      .CNT_W      (CNT_W)
   ) dut (
      .CLK                   (CLK),
      .nRST                  (nRST),
      .enable                (enable),
      .flush                 (flush),
      .valid_in              (valid_in),
      .pc4_in                (pc4_in),
      .readReg1_in           (readReg1_in),
      .readReg2_in           (readReg2_in),
      .extendedImmediate_in  (extendedImmediate_in),
      .shiftAmount_in        (shiftAmount_in),
      .aluSource_in          (aluSource_in),
      .aluOp_in              (aluOp_in),
      .rt_in                 (rt_in),
      .rd_in                 (rd_in),
      .regDst_in             (regDst_in),
      .regWrite_in           (regWrite_in),
      .memRead_in            (memRead_in),
      .memWrite_in           (memWrite_in),
      .memToReg_in           (memToReg_in),
      .branch_in             (branch_in),
      .jump_in               (jump_in),
      .halt_in               (halt_in),
      .valid_out             (valid_out),
      .pc4_out               (pc4_out),
      .readReg1_out          (readReg1_out),
      .readReg2_out          (readReg2_out),
      .extendedImmediate_out (extendedImmediate_out),
      .shiftAmount_out       (shiftAmount_out),
      .aluSource_out         (aluSource_out),
      .aluOp_out             (aluOp_out),
      .rt_out                (rt_out),
      .rd_out                (rd_out),
      .regDst_out            (regDst_out),
      .regWrite_out          (regWrite_out),
      .memRead_out           (memRead_out),
      .memWrite_out          (memWrite_out),
      .memToReg_out          (memToReg_out),
      .branch_out            (branch_out),
      .jump_out              (jump_out),
      .halt_out              (halt_out),
      .stall_cycles          (stall_cycles)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One rising edge, then settle 1 time unit so sampling is away from the edge.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic drive_instr(input logic [DATA_W-1:0] r1, input logic [DATA_W-1:0] r2,
                              input logic [DATA_W-1:0] imm, input logic [4:0] sh,
                              input logic [1:0] src, input logic [2:0] ctl);
      valid_in             = 1'b1;
      pc4_in               = r1 + 32'd4;
      readReg1_in          = r1;
      readReg2_in          = r2;
      extendedImmediate_in = imm;
      shiftAmount_in       = sh;
      aluSource_in         = src;
      aluOp_in             = 4'd2;
      rt_in                = 5'd9;
      rd_in                = 5'd17;
      regDst_in            = 2'd1;
      regWrite_in          = ctl[0];
      memWrite_in          = ctl[1];
      halt_in              = ctl[2];
      memRead_in           = 1'b0;
      memToReg_in          = 1'b0;
      branch_in            = 1'b0;
      jump_in              = 1'b0;
   endtask

   initial begin
      // Reset with nonzero inputs, checked before any clock edge
      nRST   = 1'b0;
      enable = 1'b1;
      flush  = 1'b0;
      drive_instr(32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 5'd3, 2'd1, 3'b111);
      memRead_in = 1'b1; branch_in = 1'b1; jump_in = 1'b1;
      #2;
      chk("rst_valid", valid_out, 0);
      chk("rst_rr2", readReg2_out, 0);
      chk("rst_alusrc", aluSource_out, 0);
      chk("rst_ctl", {regWrite_out, memRead_out, memWrite_out, memToReg_out,
                      branch_out, jump_out, halt_out}, 0);
      chk("rst_cnt", stall_cycles, 0);

      // Capture: visible only after the next edge
      nRST = 1'b1;
      drive_instr(32'h0000_1000, 32'hDEAD_BEEF, 32'hFFFF_FFF0, 5'd7, 2'd2, 3'b001);
      #1;
      chk("cap_pre_edge", readReg2_out, 0);
      step(1);
      chk("cap_valid", valid_out, 1);
      chk("cap_rr2", readReg2_out, 32'hDEAD_BEEF);
      chk("cap_imm", extendedImmediate_out, 32'hFFFF_FFF0);
      chk("cap_shamt", shiftAmount_out, 7);
      chk("cap_alusrc", aluSource_out, 2);
      chk("cap_regwrite", regWrite_out, 1);
      chk("cap_pc4", pc4_out, 32'h0000_1004);
      chk("cap_fields", {aluOp_out, rt_out, rd_out, regDst_out}, {4'd2, 5'd9, 5'd17, 2'd1});
      chk("cap_cnt", stall_cycles, 0);

      // Stall 3 edges while inputs change to B
      enable = 1'b0;
      drive_instr(32'h0000_2000, 32'hCAFE_F00D, 32'h0000_0010, 5'd1, 2'd1, 3'b111);
      step(3);
      chk("stall_rr2", readReg2_out, 32'hDEAD_BEEF);
      chk("stall_alusrc", aluSource_out, 2);
      chk("stall_memwrite", memWrite_out, 0);
      chk("stall_cnt", stall_cycles, 3);
      enable = 1'b1;
      step(1);
      chk("resume_rr2", readReg2_out, 32'hCAFE_F00D);
      chk("resume_ctl", {memWrite_out, halt_out, regWrite_out}, 3'b111);
      chk("resume_alusrc", aluSource_out, 1);
      chk("resume_cnt", stall_cycles, 3);

      // Flush together with stall: bubble loads, counter unchanged
      enable = 1'b0;
      flush  = 1'b1;
      step(1);
      chk("flush_valid", valid_out, 0);
      chk("flush_ctl", {regWrite_out, memWrite_out, halt_out}, 0);
      chk("flush_alusrc", aluSource_out, 0);
      chk("flush_data", {readReg2_out, aluOp_out, rd_out}, 0);
      chk("flush_cnt", stall_cycles, 3);

      // Reserved ALU source and a valid_in=0 bubble are captured verbatim
      flush  = 1'b0;
      enable = 1'b1;
      drive_instr(32'h0000_3000, 32'h0000_00AA, 32'h0, 5'd0, 2'd3, 3'b000);
      valid_in = 1'b0;
      step(1);
      chk("rsvd_alusrc", aluSource_out, 3);
      chk("bubble_valid", valid_out, 0);
      chk("bubble_rr2", readReg2_out, 32'h0000_00AA);

      // Saturation: 3 -> 14, then 3 more edges stick at 15
      enable = 1'b0;
      step(11);
      chk("sat_14", stall_cycles, 4'hE);
      step(3);
      chk("sat_15", stall_cycles, 4'hF);
      chk("sat_hold_rr2", readReg2_out, 32'h0000_00AA);

      // Reset mid-stall with count 5 clears immediately
      nRST = 1'b0;
      #2;
      nRST = 1'b1;
      enable = 1'b1;
      drive_instr(32'h0000_4000, 32'h1234_5678, 32'h0000_0004, 5'd2, 2'd1, 3'b001);
      step(1);
      chk("midA_rr2", readReg2_out, 32'h1234_5678);
      enable = 1'b0;
      step(5);
      chk("mid_cnt5", stall_cycles, 5);
      nRST = 1'b0;
      #2;
      chk("mid_rst_valid", valid_out, 0);
      chk("mid_rst_rr2", readReg2_out, 0);
      chk("mid_rst_cnt", stall_cycles, 0);
      nRST = 1'b1;
      enable = 1'b1;
      drive_instr(32'h0000_5000, 32'h0BAD_F00D, 32'h0, 5'd4, 2'd2, 3'b010);
      step(1);
      chk("post_rst_rr2", readReg2_out, 32'h0BAD_F00D);
      chk("post_rst_ctl", {valid_out, memWrite_out, regWrite_out}, 3'b110);
      chk("post_rst_cnt", stall_cycles, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
